phy_rx: RTL and testbench

//  Receive end of the two-lane serial PHY link. Deserialises phy lanes 0/1 (MSB-first, 8 bits/byte),

---
 rtl/phy_rx.sv | 203 ++++++++++++++++++++
 tb/tb_phy_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | phy_rx : two-lane serial PHY receiver - BC byte alignment, 32-bit word   |
// |          assembly per lane and lane 0 / lane 1 un-striping.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module phy_rx #(
  parameter logic [7:0]  BC_SYMBOL = 8'hBC,
  parameter int unsigned BC_COUNT  = 4
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        phy_rx_in_0,
  input  logic        phy_rx_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out,
  output logic        error_out
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCK   = 2'd1,
    ST_ACTIVE = 2'd2
  } lane_state_e;

  localparam logic [3:0] C_BC_COUNT = 4'(BC_COUNT);

  logic [1:0]  w_lane_in;
  logic [1:0]  w_lane_active;
  logic [1:0]  w_word_done;
  logic [1:0]  w_abort;
  logic [31:0] w_word [2];

  assign w_lane_in = {phy_rx_in_1, phy_rx_in_0};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    lane_state_e state_q, state_d;
    // Only the last 7 bits are stored; the 8th is the live input bit.
    logic [6:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  bc_cnt_q, bc_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] acc_q, acc_d;
    logic [7:0]  w_byte;
    logic        w_is_bc;
    logic        w_boundary;
    logic        w_done;
    logic        w_abrt;

    always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
        state_q    <= ST_SEARCH;
        sr_q       <= '0;
        bit_cnt_q  <= '0;
        bc_cnt_q   <= '0;
        byte_idx_q <= '0;
        acc_q      <= '0;
      end else begin
        state_q    <= state_d;
        sr_q       <= sr_d;
        bit_cnt_q  <= bit_cnt_d;
        bc_cnt_q   <= bc_cnt_d;
        byte_idx_q <= byte_idx_d;
        acc_q      <= acc_d;
      end
    end

    always_comb begin
      w_byte     = {sr_q, w_lane_in[l]};
      w_is_bc    = (w_byte == BC_SYMBOL);
      w_boundary = (bit_cnt_q == 3'd7);
      sr_d       = w_byte[6:0];
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      bc_cnt_d   = bc_cnt_q;
      byte_idx_d = byte_idx_q;
      acc_d      = acc_q;
      w_done     = 1'b0;
      w_abrt     = 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (w_is_bc) begin
            bit_cnt_d = 3'd0;
            bc_cnt_d  = 4'd1;
            state_d   = (C_BC_COUNT == 4'd1) ? ST_ACTIVE : ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_boundary) begin
            if (w_is_bc) begin
              bc_cnt_d = bc_cnt_q + 4'd1;
              if (bc_cnt_q + 4'd1 == C_BC_COUNT) begin
                state_d = ST_ACTIVE;
              end
            end else begin
              bc_cnt_d = 4'd0;
              state_d  = ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_boundary) begin
            if (w_is_bc) begin
              // Idle in the middle of a word: the partial word is lost.
              if (byte_idx_q != 2'd0) begin
                w_abrt = 1'b1;
              end
              byte_idx_d = 2'd0;
            end else begin
              case (byte_idx_q)
                2'd0:    acc_d[23:16] = w_byte;
                2'd1:    acc_d[15:8]  = w_byte;
                2'd2:    acc_d[7:0]   = w_byte;
                default: w_done       = 1'b1;
              endcase
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    assign w_word[l]        = {acc_q, w_byte};
    assign w_word_done[l]   = w_done;
    assign w_abort[l]       = w_abrt;
    assign w_lane_active[l] = (state_q == ST_ACTIVE);
  end

  logic [31:0] hold_q [2];
  logic [31:0] hold_d [2];
  logic [1:0]  hold_full_q, hold_full_d;
  logic        ptr_q, ptr_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        error_q, error_d;
  logic        w_drain;
  logic        w_overrun;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        hold_q[i] <= '0;
      end
      hold_full_q <= '0;
      ptr_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        hold_q[i] <= hold_d[i];
      end
      hold_full_q <= hold_full_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = hold_q[i];
    end
    hold_full_d = hold_full_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    w_overrun   = 1'b0;
    w_drain     = active_q & hold_full_q[ptr_q];
    if (w_drain) begin
      data_d             = hold_q[ptr_q];
      valid_d            = 1'b1;
      hold_full_d[ptr_q] = 1'b0;
      ptr_d              = ~ptr_q;
    end
    // A load after the drain above wins when both hit the same holding register.
    for (int i = 0; i < 2; i++) begin
      if (w_word_done[i] && active_q) begin
        if (hold_full_q[i] && !(w_drain && (ptr_q == 1'(i)))) begin
          w_overrun = 1'b1;
        end
        hold_d[i]      = w_word[i];
        hold_full_d[i] = 1'b1;
      end
    end
    active_d = &w_lane_active;
    error_d  = error_q | (|w_abort) | w_overrun;
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign active_out = active_q;
  assign error_out  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_phy_rx : directed bench for phy_rx - reset, lock, data, skew, abort.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_phy_rx;

  localparam logic [7:0] C_BC = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset_L = 1'b0;
  logic        phy_rx_in_0 = 1'b0;
  logic        phy_rx_in_1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
  logic        error_out;

  phy_rx dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .phy_rx_in_0 (phy_rx_in_0),
    .phy_rx_in_1 (phy_rx_in_1),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active_out  (active_out),
    .error_out   (error_out)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic [3:0][7:0] b0;
    logic [3:0][7:0] b1;
    logic [31:0]     exp0;
    logic [31:0]     exp1;
    int              exp_gap;
  } vec_t;

  vec_t        tbl [5];
  bit          q0 [$];
  bit          q1 [$];
  bit          auto_idle = 1'b0;
  logic [31:0] got_q [$];
  int          got_cyc [$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic push_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) q0.push_back(b[i]);
      else           q1.push_back(b[i]);
    end
  endtask

  task automatic push_bit(input int lane, input bit b);
    if (lane == 0) q0.push_back(b);
    else           q1.push_back(b);
  endtask

  task automatic push_vec(input vec_t v);
    for (int i = 3; i >= 0; i--) begin
      push_byte(0, v.b0[i]);
      push_byte(1, v.b1[i]);
    end
  endtask

  // Serial driver: lanes idle with whole BC bytes once the link is up.
  always @(negedge clk_32f) begin
    if (q0.size() == 0 && auto_idle) push_byte(0, C_BC);
    if (q1.size() == 0 && auto_idle) push_byte(1, C_BC);
    if (q0.size() != 0) phy_rx_in_0 = q0.pop_front();
    else                phy_rx_in_0 = 1'b0;
    if (q1.size() != 0) phy_rx_in_1 = q1.pop_front();
    else                phy_rx_in_1 = 1'b0;
  end

  always @(posedge clk_32f) begin
    cyc++;
    #1;
    if (valid_out) begin
      got_q.push_back(data_out);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -100000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_32f);
    #2;
  endtask

  task automatic wait_q0_empty(input string name);
    for (int k = 0; k < 64; k++) begin
      tick(1);
      if (q0.size() == 0) return;
    end
    fail_timeout(name);
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (got_q.size() >= n) return;
      tick(1);
    end
    fail_timeout(name);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},   data_out,          32'h0);
    check({tag, "_valid"},  32'(valid_out),    32'h0);
    check({tag, "_active"}, 32'(active_out),   32'h0);
    check({tag, "_error"},  32'(error_out),    32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int n0;

    tbl[0] = '{b0: {8'hAA, 8'hBB, 8'hCC, 8'hDD}, b1: {8'h11, 8'h22, 8'h33, 8'h44},
               exp0: 32'hAABBCCDD, exp1: 32'h11223344, exp_gap: 1};
    tbl[1] = '{b0: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, b1: {8'h01, 8'h23, 8'h45, 8'h67},
               exp0: 32'hDEADBEEF, exp1: 32'h01234567, exp_gap: 5};
    tbl[2] = '{b0: {8'h00, 8'hFF, 8'h00, 8'hFF}, b1: {8'h55, 8'hAA, 8'h55, 8'hAA},
               exp0: 32'h00FF00FF, exp1: 32'h55AA55AA, exp_gap: 5};
    tbl[3] = '{b0: {8'h89, 8'hAB, 8'hCD, 8'hEF}, b1: {8'hFE, 8'hDC, 8'hBA, 8'h98},
               exp0: 32'h89ABCDEF, exp1: 32'hFEDCBA98, exp_gap: 5};
    tbl[4] = '{b0: {8'h13, 8'h57, 8'h9B, 8'hDF}, b1: {8'h24, 8'h68, 8'hAC, 8'hE0},
               exp0: 32'h13579BDF, exp1: 32'h2468ACE0, exp_gap: 5};

    // Reset held while the lanes toggle.
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_byte(0, 8'($urandom_range(0, 255)));
      push_byte(1, 8'($urandom_range(0, 255)));
    end
    push_byte(0, C_BC);
    push_byte(1, C_BC);
    tick(40);
    check_outputs_zero("rst");
    reset_L = 1'b1;
    tick(20);
    check("post_rst_active", 32'(active_out), 32'h0);
    check("post_rst_words",  32'(got_q.size()), 32'h0);

    // Three BCs, a non-BC byte, then a single BC: must not reach ACTIVE.
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 3; i++) push_bit(l, 1'b0);
      for (int i = 0; i < 3; i++) push_byte(l, C_BC);
      push_byte(l, 8'h00);
      push_byte(l, C_BC);
    end
    tick(60);
    check("lock_3bc_active", 32'(active_out), 32'h0);

    // 3 stray bits + 4 BCs: active_out rises one cycle after the last BC bit.
    for (int l = 0; l < 2; l++) begin
      push_bit(l, 1'b1);
      push_bit(l, 1'b1);
      push_bit(l, 1'b0);
      for (int i = 0; i < 4; i++) push_byte(l, C_BC);
    end
    auto_idle = 1'b1;
    repeat (35) @(negedge clk_32f);
    @(posedge clk_32f);
    #2;
    check("lock_pre_active", 32'(active_out), 32'h0);
    tick(1);
    check("lock_active",   32'(active_out),    32'h1);
    check("lock_error",    32'(error_out),     32'h0);
    check("lock_no_words", 32'(got_q.size()),  32'h0);

    // Aligned lanes: consecutive output cycles, fixed latency.
    got_q.delete();
    got_cyc.delete();
    wait_q0_empty("data_align");
    push_vec(tbl[0]);
    pc = cyc;
    wait_words(2, 120, "data_words");
    check("data_word0",   word_at(0), tbl[0].exp0);
    check("data_word1",   word_at(1), tbl[0].exp1);
    check("data_latency", 32'(cyc_at(0) - pc), 32'd33);
    check("data_gap",     32'(cyc_at(1) - cyc_at(0)), 32'(tbl[0].exp_gap));
    check("data_error",   32'(error_out), 32'h0);

    // Relock with lane 1 trailing lane 0 by 5 bits.
    reset_L   = 1'b0;
    auto_idle = 1'b0;
    q0.delete();
    q1.delete();
    tick(3);
    reset_L = 1'b1;
    for (int i = 0; i < 5; i++) push_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push_byte(0, C_BC);
      push_byte(1, C_BC);
    end
    auto_idle = 1'b1;
    tick(60);
    check("skew_lock", 32'(active_out), 32'h1);
    got_q.delete();
    got_cyc.delete();
    wait_q0_empty("skew_align");
    for (int v = 1; v < 5; v++) push_vec(tbl[v]);
    wait_words(8, 400, "skew_words");
    for (int v = 1; v < 5; v++) begin
      check($sformatf("skew_l0_w%0d", v), word_at(2*v - 2), tbl[v].exp0);
      check($sformatf("skew_l1_w%0d", v), word_at(2*v - 1), tbl[v].exp1);
      check($sformatf("skew_gap%0d", v),
            32'(cyc_at(2*v - 1) - cyc_at(2*v - 2)), 32'(tbl[v].exp_gap));
    end
    check("skew_error", 32'(error_out), 32'h0);

    // Partial word on lane 0 cut short by an idle.
    n0 = got_q.size();
    wait_q0_empty("abort_align");
    push_byte(0, 8'h12);
    push_byte(0, 8'h34);
    tick(40);
    check("abort_no_word", 32'(got_q.size()), 32'(n0));
    check("abort_error",   32'(error_out),    32'h1);
    wait_q0_empty("abort_align2");
    push_byte(0, 8'hCA);
    push_byte(0, 8'hFE);
    push_byte(0, 8'hF0);
    push_byte(0, 8'h0D);
    wait_words(n0 + 1, 100, "abort_recover");
    check("abort_recover_word", word_at(n0), 32'hCAFEF00D);
    check("abort_error_sticky", 32'(error_out), 32'h1);

    // Asynchronous reset in the middle of a word clears everything.
    wait_q0_empty("midrst_align");
    push_byte(0, 8'hAA);
    push_byte(0, 8'hBB);
    tick(10);
    reset_L = 1'b0;
    #1;
    check_outputs_zero("midrst");
    tick(2);
    reset_L = 1'b1;
    tick(10);
    check("relock_needed", 32'(active_out), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
